aes_key_schedule_store: RTL and testbench
=========================================

Name: aes_key_schedule_store

Overview:
- Sequential AES-128 key schedule controller sitting directly around the single-round key expansion stage.
- Accepts a 128-bit cipher key and iterates the expansion stage once per clock to produce round keys 0..10.
- Stores all 11 round keys and exposes a registered random-access read port.
- Lets the UART decryption datapath consume keys in reverse order (round 10 down to 0) without re-expanding.

Parameters:
- NR, 10, number of expansion rounds (AES-128 only; other values unsupported)
- RW, 4, width of round index

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- key_i  input  128  cipher key, word 0 in [127:96]
- key_valid_i  input  1  key_i valid
- key_ready_o  output  1  block can accept a new key
- keys_valid_o  output  1  all 11 round keys are stored and readable
- busy_o  output  1  expansion in progress
- rd_round_i  input  RW  round index to read, 0..10
- rd_key_o  output  128  round key for the rd_round_i sampled on the previous edge

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - state=IDLE, round counter=0, all 11 key slots=0.
  - key_ready_o=1, keys_valid_o=0, busy_o=0, rd_key_o=0.
- FSM states:
  - IDLE: key_ready_o=1. Handshake (key_valid_i & key_ready_o) writes key_i to slot 0 and to the working register, sets counter=1, goes to EXPAND.
  - EXPAND: key_ready_o=0, busy_o=1. Each cycle the expansion stage is fed the working register, with select_i=counter-1 (rcon 01,02,04,...,1b,36). The result is written to slot[counter] and to the working register; counter increments. The cycle that writes slot 10 moves to READY.
  - READY: keys_valid_o=1, key_ready_o=1. A new handshake behaves as in IDLE and clears keys_valid_o on the same edge (rekey).
- Latency: handshake on edge N -> slot r written on edge N+r -> keys_valid_o high from edge N+10. Exactly 10 EXPAND cycles.
- Read port:
  - rd_key_o <= slot[rd_round_i] every edge, so there is 1-cycle latency.
  - Reads are allowed in any state; the returned data is meaningful only while keys_valid_o=1.
  - rd_round_i > 10 -> rd_key_o <= 0.
- key_valid_i during EXPAND: ignored and not queued. The source must hold it until key_ready_o.
- Simultaneous read and rekey in READY: the read returns the pre-rekey slot value for index r>0; index 0 returns the old key this edge and the new key from the next edge.
- Reset mid-EXPAND: immediate return to reset values; the partial schedule is discarded.
- Arithmetic: purely XOR/S-box in the sub-module. The counter saturates at 10 and never wraps.

Optional Feature:
- Macro: AES_KEY_SCHED_ZEROIZE_EN
- With the macro defined:
  - Extra input zeroize_i (1 bit).
  - When zeroize_i=1 on an edge: all slots, the working register and rd_key_o are cleared to 0, state -> IDLE, keys_valid_o=0.
  - Zeroize takes priority over any handshake on the same edge.
- Without the macro: the port is absent and stored keys persist until rekey or rst.

Decomposition:
- Shared package aes_pkg holds:
  - AES_NR=10
  - round-index width
  - FSM state enum {IDLE, EXPAND, READY}
  - the 128-bit key word type
- Sub-module: aes_key_expand_128, the existing combinational single-round expansion stage (select_i, key, key_out), instantiated once.
- Storage is a flop array of 11x128, so the asynchronous reset clears it.

Test Plan:
- FIPS-197 key: rst, then key_i=2b7e151628aed2a6abf7158809cf4f3c with one-cycle valid.
  - keys_valid_o rises exactly 10 edges later.
  - Read round 1 -> a0fafe1788542cb123a339392a6c7605.
  - Read round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Read round 0 -> the input key.
- Reverse read sweep: rd_round_i=10..0 on consecutive cycles -> each key appears one cycle after its index; rd_round_i=15 -> 0.
- Valid during busy: hold key_valid_i high with a second key through EXPAND.
  - key_ready_o stays 0 for 10 cycles.
  - The second key is accepted on the first READY edge.
  - keys_valid_o drops for 10 cycles, then slot 10 matches the second key's schedule.
- Reset mid-expansion: assert rst after 5 EXPAND cycles.
  - Outputs immediately return to reset values.
  - All slots read 0.
  - A fresh key afterwards yields the correct FIPS-197 schedule.
- Rekey timing: in READY, present key 000102030405060708090a0b0c0d0e0f.
  - keys_valid_o falls on the accept edge.
  - Round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- With AES_KEY_SCHED_ZEROIZE_EN: zeroize_i pulsed in READY coincident with a key handshake.
  - All reads return 0, keys_valid_o=0, state IDLE.
  - The handshake is dropped.

Source files
------------

// File: rtl/aes_key_schedule_store_pkg.sv
// rtl/aes_key_schedule_store_pkg.sv - shared AES-128 key schedule types, constants and GF(2^8) helpers
// Package aes_pkg: round count, round-index width, FSM state enum, key type,
// S-box (computed as GF(2^8) inverse plus affine map) and round-constant lookup.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_RW = 4;

    typedef logic [127:0] aes_key_t;

    typedef enum logic [1:0] {IDLE, EXPAND, READY} aes_state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (0 maps to 0), followed by the AES affine transform.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] sel);
        case (sel)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_schedule_store_if.sv
// rtl/aes_key_schedule_store_if.sv - key load / round-key read bundle for the key schedule store
// Signals: key_i, key_valid_i, key_ready_o (key handshake); keys_valid_o, busy_o (status);
// rd_round_i, rd_key_o (registered read port); zeroize_i only when AES_KEY_SCHED_ZEROIZE_EN.
// slave modport faces the key schedule store, master modport faces its user.
interface aes_key_schedule_store_if #(parameter int RW = 4);
    import aes_pkg::*;

    aes_key_t        key_i;
    logic            key_valid_i;
    logic            key_ready_o;
    logic            keys_valid_o;
    logic            busy_o;
    logic [RW-1:0]   rd_round_i;
    aes_key_t        rd_key_o;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    logic            zeroize_i;

    modport slave  (input  key_i, key_valid_i, rd_round_i, zeroize_i,
                    output key_ready_o, keys_valid_o, busy_o, rd_key_o);
    modport master (output key_i, key_valid_i, rd_round_i, zeroize_i,
                    input  key_ready_o, keys_valid_o, busy_o, rd_key_o);
`else
    modport slave  (input  key_i, key_valid_i, rd_round_i,
                    output key_ready_o, keys_valid_o, busy_o, rd_key_o);
    modport master (output key_i, key_valid_i, rd_round_i,
                    input  key_ready_o, keys_valid_o, busy_o, rd_key_o);
`endif
endinterface

// File: rtl/aes_key_schedule_store_expand.sv
// rtl/aes_key_schedule_store_expand.sv - combinational single-round AES-128 key expansion stage
// Ports: select_i (round constant index 0..9), key (previous round key), key_out (next round key).
module aes_key_expand_128
    import aes_pkg::*;
(
    input  logic [3:0] select_i,
    input  aes_key_t   key,
    output aes_key_t   key_out
);
    logic [31:0] w0, w1, w2, w3, rot, sub, tmp, n0, n1, n2, n3;

    assign w0  = key[127:96];
    assign w1  = key[95:64];
    assign w2  = key[63:32];
    assign w3  = key[31:0];
    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {aes_sbox(rot[31:24]), aes_sbox(rot[23:16]),
                  aes_sbox(rot[15:8]),  aes_sbox(rot[7:0])};
    assign tmp = sub ^ {aes_rcon(select_i), 24'h000000};
    assign n0  = w0 ^ tmp;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign key_out = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_key_schedule_store.sv
// rtl/aes_key_schedule_store.sv - sequential AES-128 key schedule with 11-entry round key store
// Ports: clk, rst (async, active-high), bus (aes_key_schedule_store_if.slave: key handshake,
// status, registered random-access read). Optional macro AES_KEY_SCHED_ZEROIZE_EN adds zeroize_i.
module aes_key_schedule_store
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int RW = AES_RW
) (
    input  logic                      clk,
    input  logic                      rst,
    aes_key_schedule_store_if.slave   bus
);
    localparam logic [RW-1:0] LAST = RW'(NR);

    aes_state_t     state, state_nx;
    aes_key_t       slots [0:NR];
    aes_key_t       work, exp_out, rd_key;
    logic [RW-1:0]  cnt;
    logic [3:0]     sel;
    logic           accept, zero;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    assign zero = bus.zeroize_i;
`else
    assign zero = 1'b0;
`endif

    // Zeroize wins over a coincident handshake, so the key is never captured.
    assign accept = bus.key_valid_i && (state != EXPAND) && !zero;
    assign sel    = 4'(cnt - RW'(1));

    aes_key_expand_128 u_expand (
        .select_i (sel),
        .key      (work),
        .key_out  (exp_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXPAND;
            EXPAND:  if (cnt == LAST) state_nx = READY;
            READY:   if (accept) state_nx = EXPAND;
            default: state_nx = IDLE;
        endcase
        if (zero) state_nx = IDLE;
    end

    always_comb begin
        bus.key_ready_o  = 1'b1;
        bus.busy_o       = 1'b0;
        bus.keys_valid_o = 1'b0;
        case (state)
            EXPAND: begin
                bus.key_ready_o = 1'b0;
                bus.busy_o      = 1'b1;
            end
            READY:   bus.keys_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            work   <= '0;
            rd_key <= '0;
            for (int i = 0; i <= NR; i++) slots[i] <= '0;
        end else if (zero) begin
            cnt    <= '0;
            work   <= '0;
            rd_key <= '0;
            for (int i = 0; i <= NR; i++) slots[i] <= '0;
        end else begin
            // Read sees the pre-edge slot contents, so a rekey read of slot 0 returns the old key.
            rd_key <= (bus.rd_round_i <= LAST) ? slots[bus.rd_round_i] : '0;
            if (accept) begin
                slots[0] <= bus.key_i;
                work     <= bus.key_i;
                cnt      <= RW'(1);
            end else if (state == EXPAND) begin
                slots[cnt] <= exp_out;
                work       <= exp_out;
                if (cnt != LAST) cnt <= cnt + RW'(1);
            end
        end
    end

    assign bus.rd_key_o = rd_key;
endmodule

// File: tb/tb_aes_key_schedule_store.sv
// tb/tb_aes_key_schedule_store.sv - scoreboard bench for aes_key_schedule_store with FIPS-197 vectors
module tb_aes_key_schedule_store;
    import aes_pkg::*;

    typedef struct {
        string          name;
        bit             kind;   // 0: rd_key_o, 1: {key_ready_o, keys_valid_o, busy_o}
        logic [127:0]   exp;
    } chk_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    chk_t exp_q[$];
    chk_t arm_q[$];
    logic [127:0] fips_rk [0:10];
    logic [127:0] k2;
    logic [127:0] k2_r10;

    aes_key_schedule_store_if #(.RW(4)) bus ();

    aes_key_schedule_store #(.NR(10), .RW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: entries queued before an edge are compared after that edge, at the falling edge.
    initial begin
        chk_t c;
        logic [127:0] got;
        forever begin
            @(posedge clk);
            while (exp_q.size() > 0) arm_q.push_back(exp_q.pop_front());
            @(negedge clk);
            while (arm_q.size() > 0) begin
                c = arm_q.pop_front();
                got = c.kind ? {125'd0, bus.key_ready_o, bus.keys_valid_o, bus.busy_o} : bus.rd_key_o;
                n_checks++;
                if (got === c.exp) n_pass++;
                else $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_status(input string name, input bit rdy, input bit kv, input bit bsy);
        chk_t c;
        c.name = name;
        c.kind = 1'b1;
        c.exp  = {125'd0, rdy, kv, bsy};
        exp_q.push_back(c);
    endtask

    task automatic expect_rd(input string name, input int round, input logic [127:0] val);
        chk_t c;
        bus.rd_round_i = 4'(round);
        c.name = name;
        c.kind = 1'b0;
        c.exp  = val;
        exp_q.push_back(c);
    endtask

    task automatic load_key(input logic [127:0] k);
        bus.key_i       = k;
        bus.key_valid_i = 1'b1;
        tick();
        bus.key_valid_i = 1'b0;
    endtask

    // Called at the falling edge after the accept edge; checks busy for 9 edges, ready on the 10th.
    task automatic expand_checks(input string tag);
        for (int i = 1; i <= 10; i++) begin
            if (i < 10) expect_status($sformatf("%s_busy%0d", tag, i), 1'b0, 1'b0, 1'b1);
            else        expect_status($sformatf("%s_ready", tag), 1'b1, 1'b1, 1'b0);
            tick();
        end
    endtask

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        k2          = 128'h000102030405060708090a0b0c0d0e0f;
        k2_r10      = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        n_checks = 0;
        n_pass   = 0;
        rst             = 1'b1;
        bus.key_i       = '0;
        bus.key_valid_i = 1'b0;
        bus.rd_round_i  = '0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        bus.zeroize_i   = 1'b0;
`endif
        tick();
        expect_status("rst_status", 1'b1, 1'b0, 1'b0);
        expect_rd("rst_rd0", 0, '0);
        tick();
        rst = 1'b0;
        tick();

        // FIPS-197 key, single-cycle valid
        load_key(fips_rk[0]);
        expand_checks("fips");
        expect_rd("fips_r1", 1, fips_rk[1]);
        tick();
        expect_rd("fips_r10", 10, fips_rk[10]);
        tick();
        expect_rd("fips_r0", 0, fips_rk[0]);
        tick();

        // Reverse read sweep, then out-of-range indices
        for (int r = 10; r >= 0; r--) begin
            expect_rd($sformatf("sweep_r%0d", r), r, fips_rk[r]);
            tick();
        end
        expect_rd("sweep_r15", 15, '0);
        tick();
        expect_rd("sweep_r11", 11, '0);
        tick();

        // Valid held through EXPAND with a second key
        bus.key_i       = fips_rk[0];
        bus.key_valid_i = 1'b1;
        tick();
        bus.key_i = k2;
        for (int i = 1; i <= 11; i++) begin
            if (i < 10)       expect_status($sformatf("hold_busy%0d", i), 1'b0, 1'b0, 1'b1);
            else if (i == 10) expect_status("hold_ready", 1'b1, 1'b1, 1'b0);
            else              expect_status("hold_accept2", 1'b0, 1'b0, 1'b1);
            tick();
        end
        bus.key_valid_i = 1'b0;
        expand_checks("k2");
        expect_rd("k2_r10", 10, k2_r10);
        tick();
        expect_rd("k2_r0", 0, k2);
        tick();

        // Reset after 5 EXPAND cycles
        load_key(fips_rk[0]);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        expect_status("midrst_status", 1'b1, 1'b0, 1'b0);
        expect_rd("midrst_rd", 3, '0);
        tick();
        rst = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            expect_rd($sformatf("cleared_r%0d", r), r, '0);
            tick();
        end
        load_key(fips_rk[0]);
        expand_checks("fresh");
        expect_rd("fresh_r1", 1, fips_rk[1]);
        tick();
        expect_rd("fresh_r10", 10, fips_rk[10]);
        tick();

        // Rekey in READY: keys_valid_o falls on accept, slot 0 read returns old then new
        bus.key_i       = k2;
        bus.key_valid_i = 1'b1;
        expect_rd("rekey_rd0_old", 0, fips_rk[0]);
        expect_status("rekey_accept", 1'b0, 1'b0, 1'b1);
        tick();
        bus.key_valid_i = 1'b0;
        expect_rd("rekey_rd0_new", 0, k2);
        tick();
        for (int i = 2; i <= 10; i++) begin
            if (i < 10) expect_status($sformatf("rekey_busy%0d", i), 1'b0, 1'b0, 1'b1);
            else        expect_status("rekey_ready", 1'b1, 1'b1, 1'b0);
            tick();
        end
        expect_rd("rekey_r10", 10, k2_r10);
        tick();

`ifdef AES_KEY_SCHED_ZEROIZE_EN
        // Zeroize coincident with a handshake: clears everything, handshake dropped
        bus.zeroize_i   = 1'b1;
        bus.key_i       = fips_rk[0];
        bus.key_valid_i = 1'b1;
        expect_status("zero_status", 1'b1, 1'b0, 1'b0);
        tick();
        bus.zeroize_i   = 1'b0;
        bus.key_valid_i = 1'b0;
        expect_rd("zero_rdkey", 10, '0);
        tick();
        expect_status("zero_idle", 1'b1, 1'b0, 1'b0);
        for (int r = 0; r <= 10; r++) begin
            expect_rd($sformatf("zero_r%0d", r), r, '0);
            tick();
        end
`endif

        tick();
        tick();
        n_checks++;
        if (exp_q.size() + arm_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size() + arm_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
